// File: rtl/fir_cfg_ctrl.sv
// fir_cfg_ctrl: AXI-Lite config/control front end, tap BRAM arbiter and IDLE/RUN/DONE sequencer for the FIR engine
module fir_cfg_ctrl #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic                   ap_start,
  output logic [31:0]            data_length,
  input  logic                   eng_done,
  input  logic                   eng_tap_req,
  input  logic [3:0]             eng_tap_idx,
  output logic                   eng_tap_vld,
  output logic [pDATA_WIDTH-1:0] eng_tap_coef,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [pADDR_WIDTH-1:0] TAP_BASE = pADDR_WIDTH'(32);
  localparam logic [pADDR_WIDTH-1:0] TAP_END  = pADDR_WIDTH'(32 + 4 * Tape_Num);
  localparam logic [pADDR_WIDTH-1:0] LEN_ADDR = pADDR_WIDTH'(16);

  logic [1:0] state;
  logic run, start_wr, clr_done, eng_go, eng_v1;
  logic wr_pend, wq, wr_issue;
  logic rd_pend, rd_busy, rq, rd_issue, rq_ff, rp_ff, rd_s1, rd_s2, rd_ff1, rd_ff2;
  logic [pADDR_WIDTH-1:0] wp_addr, wq_addr, rp_addr, rq_addr;
  logic [pDATA_WIDTH-1:0] wp_data, wq_data, rdata_q, ctrl_val, reg_val;

  function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
    return a >= TAP_BASE && a < TAP_END;
  endfunction

  assign run          = state == S_RUN;
  assign awready      = axis_rst_n & awvalid & wvalid & ~wr_pend;
  assign wready       = awready;
  assign arready      = axis_rst_n & arvalid & ~rd_busy;
  assign start_wr     = awready & awaddr == '0 & wdata[0] & ~run;
  assign clr_done     = arready & araddr == '0 & state == S_DONE;
  assign eng_go       = eng_tap_req & run;
  assign wq           = wr_pend | (awready & is_tap(awaddr) & ~run);
  assign wq_addr      = wr_pend ? wp_addr : awaddr;
  assign wq_data      = wr_pend ? wp_data : wdata;
  assign rq           = rd_pend | (arready & is_tap(araddr));
  assign rq_addr      = rd_pend ? rp_addr : araddr;
  assign rq_ff        = rd_pend ? rp_ff : run;
  assign wr_issue     = wq & ~eng_go;
  assign rd_issue     = rq & ~eng_go & ~wq;
  assign ctrl_val     = pDATA_WIDTH'({~run, state == S_DONE, run});
  assign reg_val      = araddr == '0 ? ctrl_val : araddr == LEN_ADDR ? pDATA_WIDTH'(data_length) : '0;
  assign rdata        = rd_s2 ? (rd_ff2 ? '1 : tap_Do) : rdata_q;
  assign eng_tap_coef = tap_Do;

  // Sequencer state, start pulse and data_length register
  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      state       <= S_IDLE;
      ap_start    <= 1'b0;
      data_length <= '0;
    end else begin
      state    <= start_wr ? S_RUN : (run & eng_done) ? S_DONE : clr_done ? S_IDLE : state;
      ap_start <= start_wr;
      if (awready & ~run & awaddr == LEN_ADDR) data_length <= 32'(wdata);
    end
  end

  // AXI-Lite pending tap ops, tap read pipeline and read data channel
  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      wr_pend <= 1'b0;
      wp_addr <= '0;
      wp_data <= '0;
      rd_pend <= 1'b0;
      rp_addr <= '0;
      rp_ff   <= 1'b0;
      rd_s1   <= 1'b0;
      rd_s2   <= 1'b0;
      rd_ff1  <= 1'b0;
      rd_ff2  <= 1'b0;
      rd_busy <= 1'b0;
      rvalid  <= 1'b0;
      rdata_q <= '0;
    end else begin
      wr_pend <= wq & ~wr_issue;
      wp_addr <= wq_addr;
      wp_data <= wq_data;
      rd_pend <= rq & ~rd_issue;
      rp_addr <= rq_addr;
      rp_ff   <= rq_ff;
      rd_s1   <= rd_issue;
      rd_ff1  <= rq_ff;
      rd_s2   <= rd_s1;
      rd_ff2  <= rd_ff1;
      rd_busy <= arready | (rd_busy & ~(rvalid & rready));
      rvalid  <= (arready & ~is_tap(araddr)) | rd_s1 | (rvalid & ~rready);
      if (arready & ~is_tap(araddr)) rdata_q <= reg_val;
      else if (rd_s2) rdata_q <= rdata;
    end
  end

  // Tap BRAM port (engine first, then AXI write, then AXI read) and engine valid pipeline
  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      tap_EN      <= 1'b0;
      tap_WE      <= 4'h0;
      tap_A       <= '0;
      tap_Di      <= '0;
      eng_v1      <= 1'b0;
      eng_tap_vld <= 1'b0;
    end else begin
      tap_EN      <= eng_go | wr_issue | rd_issue;
      tap_WE      <= wr_issue ? 4'hF : 4'h0;
      tap_A       <= eng_go ? pADDR_WIDTH'({eng_tap_idx, 2'b00}) : wr_issue ? wq_addr - TAP_BASE : rd_issue ? rq_addr - TAP_BASE : '0;
      tap_Di      <= wr_issue ? wq_data : '0;
      eng_v1      <= eng_go;
      eng_tap_vld <= eng_v1;
    end
  end
endmodule

// File: tb/tb_fir_cfg_ctrl.sv
// tb_fir_cfg_ctrl: directed bench with a transaction-level model of the register map, sequencer and engine fetches
module tb_fir_cfg_ctrl;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic clk = 0;
  logic rst_n = 0;
  logic awvalid = 0, wvalid = 0, arvalid = 0, rready = 0;
  logic [11:0] awaddr = 0, araddr = 0;
  logic [31:0] wdata = 0;
  logic awready, wready, arready, rvalid, ap_start, eng_tap_vld, tap_EN;
  logic [31:0] rdata, data_length, eng_tap_coef, tap_Di;
  logic [3:0] tap_WE;
  logic [11:0] tap_A;
  logic eng_done = 0, eng_tap_req = 0;
  logic [3:0] eng_tap_idx = 0;
  logic [31:0] tap_Do = 0;
  logic [31:0] mem [16] = '{default: 32'h0};

  int checks = 0;
  int failures = 0;
  int mdl_state = M_IDLE;
  logic [31:0] mdl_len = 0;
  logic [31:0] mdl_taps [11] = '{default: 32'h0};
  bit exp_start = 0;
  bit chk_on = 0;
  int coef [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

  always #5 clk = ~clk;

  fir_cfg_ctrl dut (
    .axis_clk(clk), .axis_rst_n(rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .ap_start(ap_start), .data_length(data_length),
    .eng_done(eng_done), .eng_tap_req(eng_tap_req), .eng_tap_idx(eng_tap_idx),
    .eng_tap_vld(eng_tap_vld), .eng_tap_coef(eng_tap_coef),
    .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do)
  );

  // Single-port tap BRAM with one-cycle read latency
  always @(posedge clk) begin
    if (tap_EN) begin
      if (tap_WE == 4'hF) mem[tap_A[5:2]] <= tap_Di;
      tap_Do <= mem[tap_A[5:2]];
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Per-cycle comparison of start pulse, data_length and engine fetch results against the model
  initial begin
    bit h0 = 0, h1 = 0;
    int i0 = 0, i1 = 0;
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("ap_start", {31'b0, ap_start}, {31'b0, exp_start});
        exp_start = 0;
        chk("data_length", data_length, mdl_len);
        chk("eng_vld", {31'b0, eng_tap_vld}, {31'b0, h1});
        if (h1) chk("eng_coef", eng_tap_coef, i1 < 11 ? mdl_taps[i1] : 32'h0);
      end
      h1 = h0;
      i1 = i0;
      h0 = eng_tap_req && mdl_state == M_RUN;
      i0 = int'(eng_tap_idx);
    end
  end

  task automatic axi_wr(input logic [11:0] a, input logic [31:0] d);
    int n = 0;
    @(posedge clk); #1;
    awaddr = a; wdata = d; awvalid = 1; wvalid = 1;
    @(negedge clk);
    while (!awready && n < 50) begin n++; @(negedge clk); end
    chk("wr_handshake", {30'b0, awready, wready}, 32'h3);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    if (mdl_state != M_RUN) begin
      if (a == 12'h0 && d[0]) begin mdl_state = M_RUN; exp_start = 1; end
      else if (a == 12'h10) mdl_len = d;
      else if (a >= 12'h20 && a < 12'h4C) mdl_taps[(a - 12'h20) >> 2] = d;
    end
  endtask

  task automatic rd_chk(input string nm, input logic [11:0] a, input int exp_lat, input bit hold, output logic [31:0] d);
    int n = 0;
    int lat = 0;
    logic [31:0] exp;
    bit clr;
    @(posedge clk); #1;
    araddr = a; arvalid = 1;
    @(negedge clk);
    while (!arready && n < 50) begin n++; @(negedge clk); end
    chk({nm, "_arready"}, {31'b0, arready}, 32'h1);
    exp = a == 12'h0 ? (mdl_state == M_IDLE ? 32'h4 : mdl_state == M_RUN ? 32'h1 : 32'h6) :
          a == 12'h10 ? mdl_len :
          (a >= 12'h20 && a < 12'h4C) ? (mdl_state == M_RUN ? 32'hFFFFFFFF : mdl_taps[(a - 12'h20) >> 2]) : 32'h0;
    clr = a == 12'h0 && mdl_state == M_DONE;
    @(posedge clk); #1;
    arvalid = 0;
    rready = !hold;
    if (clr) mdl_state = M_IDLE;
    do begin @(negedge clk); lat++; end while (!rvalid && lat < 100);
    d = rdata;
    chk({nm, "_data"}, d, exp);
    chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    if (!hold) begin @(posedge clk); #1; rready = 0; end
  endtask

  task automatic eng_run(input int start, input int n);
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      eng_tap_req = 1;
      eng_tap_idx = 4'(start + k);
      @(posedge clk); #1;
    end
    eng_tap_req = 0;
  endtask

  task automatic pulse_done();
    @(posedge clk); #1;
    eng_done = 1;
    @(posedge clk); #1;
    eng_done = 0;
    if (mdl_state == M_RUN) mdl_state = M_DONE;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bram", {27'b0, tap_EN, tap_WE}, 32'h0);
    chk("rst_outs", {29'b0, rvalid, ap_start, eng_tap_vld}, 32'h0);
    chk("rst_len", data_length, 32'h0);
    @(posedge clk); #1;
    rst_n = 1;
    chk_on = 1;
    rd_chk("ctrl_reset", 12'h00, 1, 0, d);
    chk("ctrl_reset_lit", d, 32'h4);
    rd_chk("len_reset", 12'h10, 1, 0, d);
    for (int i = 0; i < 11; i++) axi_wr(12'(32 + 4 * i), 32'(coef[i]));
    for (int i = 0; i < 11; i++) begin
      rd_chk("tap_rd", 12'(32 + 4 * i), 2, 0, d);
      chk("tap_lit", d, 32'(coef[i]));
    end
    axi_wr(12'h4C, 32'h55);
    rd_chk("tap_oor", 12'h4C, 1, 0, d);
    rd_chk("unmapped", 12'h08, 1, 0, d);
    eng_run(0, 3);
    pulse_done();
    rd_chk("done_in_idle", 12'h00, 1, 0, d);
    axi_wr(12'h10, 32'd600);
    fork
      rd_chk("ctrl_same_cycle", 12'h00, 1, 0, d);
      axi_wr(12'h00, 32'h1);
    join
    chk("same_cycle_lit", d, 32'h4);
    rd_chk("ctrl_run", 12'h00, 1, 0, d);
    chk("ctrl_run_lit", d, 32'h1);
    axi_wr(12'h24, 32'd7);
    axi_wr(12'h10, 32'd5);
    axi_wr(12'h00, 32'h1);
    fork
      rd_chk("tap_rd_stall", 12'h24, 13, 0, d);
      eng_run(0, 11);
    join
    eng_run(11, 1);
    eng_run(5, 2);
    repeat (3) @(posedge clk);
    pulse_done();
    rd_chk("ctrl_done", 12'h00, 1, 0, d);
    chk("ctrl_done_lit", d, 32'h6);
    rd_chk("ctrl_after_done", 12'h00, 1, 0, d);
    chk("ctrl_after_done_lit", d, 32'h4);
    rd_chk("tap1_after_run", 12'h24, 2, 0, d);
    chk("tap1_after_run_lit", d, 32'hFFFFFFF6);
    axi_wr(12'h00, 32'h1);
    pulse_done();
    axi_wr(12'h00, 32'h1);
    rd_chk("ctrl_restart", 12'h00, 1, 0, d);
    chk("ctrl_restart_lit", d, 32'h1);
    rd_chk("ctrl_hold", 12'h00, 1, 1, d);
    rst_n = 0;
    @(posedge clk); #1;
    mdl_state = M_IDLE;
    mdl_len = 0;
    rst_n = 1;
    @(negedge clk);
    chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
    chk("rst_len_mid", data_length, 32'h0);
    rd_chk("ctrl_after_rst", 12'h00, 1, 0, d);
    chk("ctrl_after_rst_lit", d, 32'h4);
    rd_chk("len_after_rst", 12'h10, 1, 0, d);
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
